aes_frame_sequencer: RTL and testbench

Controller that sequences one AES-128 encryption frame between the UART receiver, the AES encryption core and a single UART transmitter. It assembles 16 received plaintext bytes into a 128-bit block and issues a start pulse to the AES core. It captures the ciphertext and streams it back as 16 bytes with a programmable inter-byte gap. It sits in the top level between uart_rx, the AES core (start/done handshake) and uart_tx, and replaces ad-hoc full/transmit logic there.

---
 rtl/aes_uart_pkg.sv | 21 ++
 rtl/gap_timer.sv | 39 +++
 rtl/aes_frame_sequencer.sv | 158 +++++++++++++++
 tb/tb_aes_frame_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES/UART frame path: state encoding and widths.
package aes_uart_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 128;
    localparam int BYTE_W      = 8;
    localparam int GAP_W       = 28;

    // Index of the final byte in a block, sized for the 4-bit byte counters.
    localparam logic [3:0] LAST_BYTE = 4'(BLOCK_BYTES - 1);

    // Frame sequencer states; the encoding is exported on the LED debug port.
    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_ENCRYPT = 3'd1,
        ST_READY   = 3'd2,
        ST_SEND    = 3'd3,
        ST_GAP     = 3'd4
    } state_e;

endpackage

// File: rtl/gap_timer.sv
// GAP_W-bit down counter used to pace bytes. A load sets the count; it then
// decrements to zero and stops. expired_o is high in the last counted cycle
// (count == 1), so a load value of G gives exactly G cycles before the
// cycle in which the owner reacts to expiry.
module gap_timer
    import aes_uart_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [GAP_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [GAP_W-1:0] count_q;
    logic [GAP_W-1:0] count_d;

    // Next count: a load wins, otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - GAP_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == GAP_W'(1));

endmodule

// File: rtl/aes_frame_sequencer.sv
// Sequences one AES-128 frame: collect 16 plaintext bytes from the UART
// receiver, launch the AES core, capture the ciphertext and stream it back
// to the UART transmitter with a programmable gap between bytes.
//
// Interface semantics: every strobe (rx_dv, tx_request, aes_done, tx_done,
// aes_start, tx_dv) is a single-cycle pulse with no backpressure. A strobe
// that arrives in a state that does not expect it is ignored, except rx_dv
// outside COLLECT, which drops the byte and sets the sticky overflow flag.
// abort outranks every other event in the same cycle.
module aes_frame_sequencer
    import aes_uart_pkg::*;
#(
    parameter int GAP_CYCLES = 100000,
    parameter bit AUTO_TX    = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 abort,
    input  logic                 rx_dv,
    input  logic [BYTE_W-1:0]    rx_byte,
    input  logic                 tx_request,
    output logic                 aes_start,
    output logic [BLOCK_W-1:0]   aes_block,
    input  logic                 aes_done,
    input  logic [BLOCK_W-1:0]   aes_result,
    output logic                 tx_dv,
    output logic [BYTE_W-1:0]    tx_byte,
    input  logic                 tx_done,
    output logic                 block_ready,
    output logic                 overflow,
    output logic [2:0]           state_dbg
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    state_e               state_q;
    logic [3:0]           byte_cnt_q;
    logic [3:0]           tx_cnt_q;
    logic [BLOCK_W-1:0]   aes_block_q;
    logic [BLOCK_W-1:0]   ct_q;
    logic                 aes_start_q;
    logic                 tx_dv_q;
    logic [BYTE_W-1:0]    tx_byte_q;
    logic                 block_ready_q;
    logic                 overflow_q;
    logic                 gap_load;
    logic                 gap_expired;

    // Arm the gap timer when a non-final byte completes in SEND.
    always_comb begin
        gap_load = 1'b0;
        if (!abort && state_q == ST_SEND && tx_done && tx_cnt_q != LAST_BYTE) begin
            gap_load = 1'b1;
        end
    end

    gap_timer u_gap_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .expired_o  (gap_expired)
    );

    // Frame FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_COLLECT;
            byte_cnt_q    <= '0;
            tx_cnt_q      <= '0;
            aes_block_q   <= '0;
            ct_q          <= '0;
            aes_start_q   <= 1'b0;
            tx_dv_q       <= 1'b0;
            tx_byte_q     <= '0;
            block_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            aes_start_q <= 1'b0;
            tx_dv_q     <= 1'b0;
            if (abort) begin
                // Any in-flight AES operation keeps running; its aes_done
                // lands in COLLECT and is ignored there.
                state_q       <= ST_COLLECT;
                byte_cnt_q    <= '0;
                tx_cnt_q      <= '0;
                block_ready_q <= 1'b0;
            end else begin
                if (rx_dv && state_q != ST_COLLECT) begin
                    overflow_q <= 1'b1;
                end
                case (state_q)
                    ST_COLLECT: begin
                        if (rx_dv) begin
                            aes_block_q <= {aes_block_q[BLOCK_W-BYTE_W-1:0], rx_byte};
                            if (byte_cnt_q == LAST_BYTE) begin
                                // Counter holds at 15 until the frame completes.
                                aes_start_q <= 1'b1;
                                state_q     <= ST_ENCRYPT;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 4'd1;
                            end
                        end
                    end
                    ST_ENCRYPT: begin
                        if (aes_done) begin
                            ct_q          <= aes_result;
                            block_ready_q <= 1'b1;
                            state_q       <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (tx_request || AUTO_TX) begin
                            tx_byte_q <= ct_q[BLOCK_W-1 -: BYTE_W];
                            ct_q      <= {ct_q[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                            tx_dv_q   <= 1'b1;
                            tx_cnt_q  <= '0;
                            state_q   <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (tx_done) begin
                            if (tx_cnt_q == LAST_BYTE) begin
                                byte_cnt_q    <= '0;
                                tx_cnt_q      <= '0;
                                block_ready_q <= 1'b0;
                                state_q       <= ST_COLLECT;
                            end else begin
                                tx_cnt_q <= tx_cnt_q + 4'd1;
                                state_q  <= ST_GAP;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_expired) begin
                            tx_byte_q <= ct_q[BLOCK_W-1 -: BYTE_W];
                            ct_q      <= {ct_q[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                            tx_dv_q   <= 1'b1;
                            state_q   <= ST_SEND;
                        end
                    end
                    default: begin
                        state_q <= ST_COLLECT;
                    end
                endcase
            end
        end
    end

    assign aes_start   = aes_start_q;
    assign aes_block   = aes_block_q;
    assign tx_dv       = tx_dv_q;
    assign tx_byte     = tx_byte_q;
    assign block_ready = block_ready_q;
    assign overflow    = overflow_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_aes_frame_sequencer.sv
// Directed bench for aes_frame_sequencer: one manual-transmit instance and
// one AUTO_TX instance, both with a 4-cycle inter-byte gap.
module tb_aes_frame_sequencer;

  localparam int GAP = 4;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  logic clock = 1'b0;
  logic reset = 1'b0;

  // manual-transmit instance signals
  logic         abort = 0, rx_dv = 0, tx_request = 0, aes_done = 0, tx_done = 0;
  logic [7:0]   rx_byte = 0;
  logic [127:0] aes_result = 0;
  logic         aes_start, tx_dv, block_ready, overflow;
  logic [127:0] aes_block;
  logic [7:0]   tx_byte;
  logic [2:0]   state_dbg;

  // auto-transmit instance signals
  logic         a_abort = 0, a_rx_dv = 0, a_tx_request = 0, a_aes_done = 0, a_tx_done = 0;
  logic [7:0]   a_rx_byte = 0;
  logic [127:0] a_aes_result = 0;
  logic         a_aes_start, a_tx_dv, a_block_ready, a_overflow;
  logic [127:0] a_aes_block;
  logic [7:0]   a_tx_byte;
  logic [2:0]   a_state_dbg;

  aes_frame_sequencer #(.GAP_CYCLES(GAP), .AUTO_TX(1'b0)) dut (
    .clock(clock), .reset(reset), .abort(abort), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .tx_request(tx_request), .aes_start(aes_start), .aes_block(aes_block),
    .aes_done(aes_done), .aes_result(aes_result), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_done(tx_done), .block_ready(block_ready), .overflow(overflow), .state_dbg(state_dbg)
  );

  aes_frame_sequencer #(.GAP_CYCLES(GAP), .AUTO_TX(1'b1)) dut_auto (
    .clock(clock), .reset(reset), .abort(a_abort), .rx_dv(a_rx_dv), .rx_byte(a_rx_byte),
    .tx_request(a_tx_request), .aes_start(a_aes_start), .aes_block(a_aes_block),
    .aes_done(a_aes_done), .aes_result(a_aes_result), .tx_dv(a_tx_dv), .tx_byte(a_tx_byte),
    .tx_done(a_tx_done), .block_ready(a_block_ready), .overflow(a_overflow), .state_dbg(a_state_dbg)
  );

  // clock/reset block
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive 16 bytes base..base+15 into the manual instance, with idle cycles
  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      rx_dv = 1'b1;
      rx_byte = base + 8'(i);
      step();
      rx_dv = 1'b0;
      chk("aes_start", 128'(aes_start), (i == 15) ? 1 : 0);
      if (i % 4 == 3 && i != 15) step();
    end
  endtask

  task automatic send_frame_a(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      a_rx_dv = 1'b1;
      a_rx_byte = base + 8'(i);
      step();
      a_rx_dv = 0;
    end
    chk("a_aes_start", 128'(a_aes_start), 1);
  endtask

  // serve n bytes on the manual instance; first tx_dv must already be visible
  task automatic serve_tx(input int n_bytes);
    int cyc;
    for (int i = 0; i < n_bytes; i++) begin
      if (i > 0) begin
        cyc = 1;
        while (!tx_dv && cyc < 64) begin
          step();
          cyc++;
        end
        chk("gap_len", 128'(cyc), GAP + 1);
      end
      chk("tx_byte", 128'(tx_byte), 128'(exp_q.pop_front()));
      step();
      chk("tx_dv_width", 128'(tx_dv), 0);
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      if (i < 15) chk("gap_state", 128'(state_dbg), 4);
    end
  endtask

  initial begin
    int n_tx;
    int cyc;

    // reset state
    repeat (3) step();
    chk("rst_state", 128'(state_dbg), 0);
    chk("rst_aes_start", 128'(aes_start), 0);
    chk("rst_aes_block", aes_block, 0);
    chk("rst_tx_dv", 128'(tx_dv), 0);
    chk("rst_tx_byte", 128'(tx_byte), 0);
    chk("rst_block_ready", 128'(block_ready), 0);
    chk("rst_overflow", 128'(overflow), 0);
    chk("rst_a_state", 128'(a_state_dbg), 0);
    reset = 1'b1;
    step();

    // basic frame
    send_frame(8'h00);
    chk("f1_state", 128'(state_dbg), 1);
    chk("f1_block", aes_block, 128'h000102030405060708090A0B0C0D0E0F);
    step();
    chk("f1_start_width", 128'(aes_start), 0);

    // overflow during ENCRYPT
    rx_dv = 1'b1; rx_byte = 8'hEE;
    step();
    rx_dv = 1'b0;
    chk("ovf_set", 128'(overflow), 1);
    chk("ovf_block_held", aes_block, 128'h000102030405060708090A0B0C0D0E0F);
    chk("ovf_state", 128'(state_dbg), 1);

    // tx_request outside READY ignored
    tx_request = 1'b1;
    step();
    tx_request = 1'b0;
    chk("req_encrypt_tx_dv", 128'(tx_dv), 0);
    chk("req_encrypt_state", 128'(state_dbg), 1);

    // ciphertext capture
    aes_result = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
    chk("ready_state", 128'(state_dbg), 2);
    chk("ready_block_ready", 128'(block_ready), 1);
    chk("ready_no_auto", 128'(tx_dv), 0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    chk("ready_hold_state", 128'(state_dbg), 2);
    chk("ready_hold_tx_dv", 128'(tx_dv), 0);

    // transmit order and spacing
    for (int i = 0; i < 16; i++) exp_q.push_back(8'hA0 + 8'(i));
    tx_request = 1'b1;
    step();
    tx_request = 1'b0;
    chk("req_tx_dv", 128'(tx_dv), 1);
    serve_tx(16);
    chk("done_state", 128'(state_dbg), 0);
    chk("done_block_ready", 128'(block_ready), 0);

    // next frame starting right after the last tx_done; overflow stays set
    send_frame(8'h10);
    chk("f2_block", aes_block, 128'h101112131415161718191A1B1C1D1E1F);
    chk("f2_overflow_sticky", 128'(overflow), 1);
    step();
    aes_result = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'hB0 + 8'(i));
    tx_request = 1'b1;
    step();
    tx_request = 1'b0;
    serve_tx(8);

    // abort mid-GAP after byte 7
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_state", 128'(state_dbg), 0);
    chk("abort_block_ready", 128'(block_ready), 0);
    n_tx = 0;
    repeat (12) begin
      if (tx_dv) n_tx++;
      step();
    end
    chk("abort_no_tx", 128'(n_tx), 0);

    // aborted encryption; its late aes_done is ignored
    send_frame(8'h30);
    chk("f3_block", aes_block, 128'h303132333435363738393A3B3C3D3E3F);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_enc_state", 128'(state_dbg), 0);
    aes_result = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
    chk("stale_done_state", 128'(state_dbg), 0);
    chk("stale_done_ready", 128'(block_ready), 0);
    send_frame(8'h40);
    chk("f4_block", aes_block, 128'h404142434445464748494A4B4C4D4E4F);

    // into SEND, then reset asynchronously
    step();
    aes_result = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
    chk("f4_ready", 128'(state_dbg), 2);
    tx_request = 1'b1;
    step();
    tx_request = 1'b0;
    chk("f4_tx_dv", 128'(tx_dv), 1);
    chk("f4_tx_byte", 128'(tx_byte), 8'hC0);
    step();
    chk("f4_send", 128'(state_dbg), 3);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_state", 128'(state_dbg), 0);
    chk("arst_tx_byte", 128'(tx_byte), 0);
    chk("arst_block_ready", 128'(block_ready), 0);
    chk("arst_overflow", 128'(overflow), 0);
    chk("arst_aes_block", aes_block, 0);
    chk("arst_tx_dv", 128'(tx_dv), 0);
    step();
    reset = 1'b1;
    send_frame(8'h50);
    chk("f5_block", aes_block, 128'h505152535455565758595A5B5C5D5E5F);

    // AUTO_TX instance: abort drops a simultaneous rx_dv without overflow
    a_abort = 1'b1; a_rx_dv = 1'b1; a_rx_byte = 8'h99;
    step();
    a_abort = 1'b0; a_rx_dv = 1'b0;
    chk("a_abort_overflow", 128'(a_overflow), 0);
    chk("a_abort_block", a_aes_block, 0);
    send_frame_a(8'h60);
    chk("a_block", a_aes_block, 128'h606162636465666768696A6B6C6D6E6F);
    a_aes_result = 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF;
    a_aes_done = 1'b1;
    step();
    a_aes_done = 1'b0;
    chk("a_m1_state", 128'(a_state_dbg), 2);
    chk("a_m1_tx_dv", 128'(a_tx_dv), 0);
    step();
    chk("a_m2_tx_dv", 128'(a_tx_dv), 1);
    chk("a_m2_tx_byte", 128'(a_tx_byte), 8'hD0);
    a_tx_request = 1'b1;
    step();
    a_tx_request = 1'b0;
    chk("a_req_send_tx_dv", 128'(a_tx_dv), 0);
    chk("a_req_send_state", 128'(a_state_dbg), 3);
    a_tx_done = 1'b1;
    step();
    a_tx_done = 1'b0;
    chk("a_gap_state", 128'(a_state_dbg), 4);
    cyc = 1;
    while (!a_tx_dv && cyc < 64) begin
      step();
      cyc++;
    end
    chk("a_gap_len", 128'(cyc), GAP + 1);
    chk("a_tx_byte1", 128'(a_tx_byte), 8'hD1);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
